axil_param_regbank: RTL

//  Parametrised AXI-lite-style slave register bank; successor to the fixed 4-bit tt_um AXI demo slave.

---
 rtl/axil_param_if.sv | 36 +++
 rtl/axil_param_regbank.sv | 121 ++++++++++++
 2 files changed

// File: rtl/axil_param_if.sv
// AXI-lite-style register-bus bundle between a handshake master and the parametrised register bank.
interface axil_param_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              ms_awvalid;
  logic              sm_awready;
  logic [ADDR_W-1:0] SWM_awaddr;
  logic              ms_wvalid;
  logic              sm_wready;
  logic [DATA_W-1:0] SWM_wdata;
  logic              sm_bvalid;
  logic              ms_bready;
  logic [1:0]        sm_bresp;
  logic              ms_arvalid;
  logic              sm_arready;
  logic [ADDR_W-1:0] SWM_arADDR;
  logic              sm_rvalid;
  logic              ms_rready;
  logic [DATA_W-1:0] sm_rdata;
  logic [1:0]        sm_rresp;

  modport master (
    output ms_awvalid, SWM_awaddr, ms_wvalid, SWM_wdata, ms_bready,
           ms_arvalid, SWM_arADDR, ms_rready,
    input  sm_awready, sm_wready, sm_bvalid, sm_bresp,
           sm_arready, sm_rvalid, sm_rdata, sm_rresp
  );

  modport slave (
    input  ms_awvalid, SWM_awaddr, ms_wvalid, SWM_wdata, ms_bready,
           ms_arvalid, SWM_arADDR, ms_rready,
    output sm_awready, sm_wready, sm_bvalid, sm_bresp,
           sm_arready, sm_rvalid, sm_rdata, sm_rresp
  );
endinterface

// File: rtl/axil_param_regbank.sv
// Parametrised AXI-lite-style register bank with independent AW/W capture, B/R responses
// and a registered 7-segment view of one register.
module axil_param_regbank #(
  parameter int              ADDR_W    = 4,
  parameter int              DATA_W    = 8,
  parameter int              DEPTH     = 16,
  parameter int              DISP_SEL  = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  axil_param_if.slave      bus,
  output logic [7:0]       disp_hex_r
);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: hex7seg = 7'h3F;  4'h1: hex7seg = 7'h06;
      4'h2: hex7seg = 7'h5B;  4'h3: hex7seg = 7'h4F;
      4'h4: hex7seg = 7'h66;  4'h5: hex7seg = 7'h6D;
      4'h6: hex7seg = 7'h7D;  4'h7: hex7seg = 7'h07;
      4'h8: hex7seg = 7'h7F;  4'h9: hex7seg = 7'h6F;
      4'hA: hex7seg = 7'h77;  4'hB: hex7seg = 7'h7C;
      4'hC: hex7seg = 7'h39;  4'hD: hex7seg = 7'h5E;
      4'hE: hex7seg = 7'h79;  default: hex7seg = 7'h71;
    endcase
  endfunction

  wr_state_t         wr_state, wr_next;
  rd_state_t         rd_state, rd_next;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [DATA_W-1:0] regs [DEPTH];

  logic              aw_fire, w_fire, ar_fire, commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_mapped, rd_mapped;

  always_comb begin
    wr_next        = wr_state;
    rd_next        = rd_state;
    bus.sm_awready = !aw_held && (wr_state == WR_IDLE);
    bus.sm_wready  = !w_held && (wr_state == WR_IDLE);
    bus.sm_bvalid  = (wr_state == WR_RESP);
    bus.sm_arready = (rd_state == RD_IDLE);
    bus.sm_rvalid  = (rd_state == RD_RESP);

    aw_fire   = bus.ms_awvalid && bus.sm_awready;
    w_fire    = bus.ms_wvalid && bus.sm_wready;
    ar_fire   = bus.ms_arvalid && bus.sm_arready;
    // A held half plus its partner arriving now commits on this edge
    commit    = (aw_held || aw_fire) && (w_held || w_fire);
    wr_addr   = aw_held ? aw_addr_q : bus.SWM_awaddr;
    wr_data   = w_held ? w_data_q : bus.SWM_wdata;
    wr_mapped = 32'(wr_addr) < DEPTH;
    rd_mapped = 32'(bus.SWM_arADDR) < DEPTH;

    case (wr_state)
      WR_IDLE: if (commit) wr_next = WR_RESP;
      WR_RESP: if (bus.ms_bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
    case (rd_state)
      RD_IDLE: if (ar_fire) rd_next = RD_RESP;
      RD_RESP: if (bus.ms_rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state     <= WR_IDLE;
      rd_state     <= RD_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      bus.sm_bresp <= RESP_OKAY;
      bus.sm_rresp <= RESP_OKAY;
      bus.sm_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      disp_hex_r   <= {|RESET_VAL[DATA_W-1:4], hex7seg(RESET_VAL[3:0])};
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;

      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        bus.sm_bresp <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        if (wr_mapped) regs[wr_addr] <= wr_data;
      end else begin
        if (aw_fire) begin
          aw_held   <= 1'b1;
          aw_addr_q <= bus.SWM_awaddr;
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= bus.SWM_wdata;
        end
      end

      // Non-blocking read of regs returns the pre-edge value on a same-edge write
      if (ar_fire) begin
        bus.sm_rdata <= rd_mapped ? regs[bus.SWM_arADDR] : '0;
        bus.sm_rresp <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end

      disp_hex_r <= {|regs[DISP_SEL][DATA_W-1:4], hex7seg(regs[DISP_SEL][3:0])};
    end
  end

endmodule
